// File: rtl/audio_pkg.sv
// Shared audio constants, the canonical sample type and CIC sizing helpers
// used by the PDM receive and transmit paths.
package audio_pkg;

  localparam int PDM_COUNT_PERIOD = 32;
  localparam int NUM_PDM_SAMPLES  = 256;
  localparam int AUDIO_WIDTH      = 8;

  typedef logic signed [AUDIO_WIDTH-1:0] audio_sample_t;

  // Register width that lets an order-N CIC over a +/-1 input wrap safely.
  function automatic int cic_width(input int order, input int r);
    return 2 + order * $clog2(r);
  endfunction

endpackage : audio_pkg

// File: rtl/pdm_clock_gen.sv
// Microphone bit-clock divider: 50% duty clock from a wrapping counter and a
// one-cycle tick one clock after each rising edge of that clock.
module pdm_clock_gen
  import audio_pkg::*;
#(
  parameter int PERIOD = PDM_COUNT_PERIOD
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic mic_clk_out,
  output logic pdm_tick_out
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(PERIOD / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mic_clk_q, mic_clk_d;
  logic          mic_clk_prev_q, mic_clk_prev_d;
  logic          tick_q, tick_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d          = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    mic_clk_d      = (cnt_q < CNT_HALF);
    mic_clk_prev_d = mic_clk_q;
    tick_d         = mic_clk_q & ~mic_clk_prev_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q          <= '0;
      mic_clk_q      <= 1'b0;
      mic_clk_prev_q <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      mic_clk_q      <= mic_clk_d;
      mic_clk_prev_q <= mic_clk_prev_d;
      tick_q         <= tick_d;
    end
  end

  assign mic_clk_out  = mic_clk_q;
  assign pdm_tick_out = tick_q;

endmodule : pdm_clock_gen

// File: rtl/pdm_decimator.sv
// PDM microphone receiver: bit-clock generation, input synchronisation and a
// 2nd-order CIC decimator producing saturated signed samples with a strobe.
module pdm_decimator #(
  parameter int PDM_COUNT_PERIOD = audio_pkg::PDM_COUNT_PERIOD,
  parameter int DECIMATION       = audio_pkg::NUM_PDM_SAMPLES,
  parameter int OUT_WIDTH        = audio_pkg::AUDIO_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        mic_data_in,
  output logic                        mic_clk_out,
  output logic                        pdm_tick_out,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid_out
);
  import audio_pkg::*;

  localparam int LOG2R = $clog2(DECIMATION);
  localparam int W     = cic_width(2, DECIMATION);
  localparam int SHIFT = 2 * LOG2R - OUT_WIDTH + 1;
  localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
  localparam int SW    = W + LSH;

  localparam logic signed [SW-1:0]   SAT_MAX   = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]   SAT_MIN   = ~SAT_MAX;
  localparam logic [LOG2R-1:0]       LAST_TICK = LOG2R'(DECIMATION - 1);
  localparam logic signed [W-1:0]    X_POS     = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0]    X_NEG     = '1;

  pdm_clock_gen #(
    .PERIOD (PDM_COUNT_PERIOD)
  ) u_clock_gen (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mic_clk_out  (mic_clk_out),
    .pdm_tick_out (pdm_tick_out)
  );

  logic [1:0]                  sync_q, sync_d;
  logic [LOG2R-1:0]            tick_cnt_q, tick_cnt_d;
  logic                        dec_strobe_q, dec_strobe_d;
  logic signed [W-1:0]         i1_q, i1_d, i2_q, i2_d;
  logic signed [W-1:0]         i2_prev_q, i2_prev_d, c1_prev_q, c1_prev_d;
  logic signed [W-1:0]         x_pdm, c1, c2;
  logic signed [SW-1:0]        c2_ext, scaled;
  logic signed [OUT_WIDTH-1:0] sample_q, sample_d;
  logic                        valid_q, valid_d;

  // Integrators and frame counter advance only on the PDM tick; the counter
  // wraps naturally because DECIMATION is a power of two.
  always_comb begin
    sync_d       = {sync_q[0], mic_data_in};
    x_pdm        = sync_q[1] ? X_POS : X_NEG;
    i1_d         = i1_q;
    i2_d         = i2_q;
    tick_cnt_d   = tick_cnt_q;
    dec_strobe_d = 1'b0;
    if (pdm_tick_out) begin
      i1_d         = i1_q + x_pdm;
      i2_d         = i2_q + i1_d;
      tick_cnt_d   = tick_cnt_q + 1'b1;
      dec_strobe_d = (tick_cnt_q == LAST_TICK);
    end
  end

  // Combs run at the decimated rate; modular subtraction undoes integrator wrap.
  always_comb begin
    c1        = i2_q - i2_prev_q;
    c2        = c1 - c1_prev_q;
    c2_ext    = SW'(c2);
    scaled    = (c2_ext <<< LSH) >>> RSH;
    i2_prev_d = i2_prev_q;
    c1_prev_d = c1_prev_q;
    sample_d  = sample_q;
    valid_d   = dec_strobe_q;
    if (dec_strobe_q) begin
      i2_prev_d = i2_q;
      c1_prev_d = c1;
      if (scaled > SAT_MAX) begin
        sample_d = SAT_MAX[OUT_WIDTH-1:0];
      end else if (scaled < SAT_MIN) begin
        sample_d = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
        sample_d = scaled[OUT_WIDTH-1:0];
      end
    end
  end

  // NOTE: every flop, including the synchroniser, is cleared by the async
  // reset so an interrupted frame leaves nothing behind.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q       <= '0;
      tick_cnt_q   <= '0;
      dec_strobe_q <= 1'b0;
      i1_q         <= '0;
      i2_q         <= '0;
      i2_prev_q    <= '0;
      c1_prev_q    <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tick_cnt_q   <= tick_cnt_d;
      dec_strobe_q <= dec_strobe_d;
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i2_prev_q    <= i2_prev_d;
      c1_prev_q    <= c1_prev_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;

endmodule : pdm_decimator

// File: doc/pdm_decimator.md
# pdm_decimator

Microphone-side PDM receiver: generates the microphone bit clock, samples the 1-bit PDM stream, and decimates it with a 2nd-order CIC filter. The output is signed 8-bit audio samples, each with a single-cycle valid strobe. It is the receive-direction counterpart of the `pdm` output modulator. It replaces the ad-hoc tally/counter logic in the top level and feeds `recorder` and the playback mux.

## Interface
Parameters:
- `PDM_COUNT_PERIOD`, 32: system clocks per mic clock period; even, ≥4.
- `DECIMATION`, 256: PDM bits per output sample (R); power of two, 4..1024.
- `OUT_WIDTH`, 8: width of the signed output sample.

Ports:
- `clk_in` input 1: system clock (139.264 MHz in the current build).
- `rst_in` input 1: reset, asynchronous active-high.
- `mic_data_in` input 1: raw PDM data pin; asynchronous to `clk_in`.
- `mic_clk_out` output 1: registered microphone clock.
- `pdm_tick_out` output 1: single-cycle pulse marking each PDM bit capture.
- `sample_out` output OUT_WIDTH: signed decimated audio sample.
- `sample_valid_out` output 1: single-cycle strobe; `sample_out` is new in this cycle.

## Operation
Clock generation:
- Counter `cnt` runs 0..PERIOD-1 and wraps.
- `mic_clk_out <= (cnt < PERIOD/2)`, so the duty cycle is 50%.
- `pdm_tick_out` is high for exactly one cycle when `mic_clk_out`=1 and its previous value was 0.

Input capture:
- `mic_data_in` passes through a 2-flop synchronizer.
- On each tick the synchronized bit is mapped to x = +1 (bit 1) or -1 (bit 0).

Integrators (update on tick only):
- Width W = 2 + 2·log2(R), which is 18 for R=256.
- I1 += x, then I2 += I1, both two's-complement wrapping mod 2^W.
- Wrap-around is intentional; the comb stages recover the correct value.

Decimation:
- A tick counter runs 0..R-1.
- On the tick where it equals R-1, set the internal `dec_strobe` for the next cycle.

Combs (update on `dec_strobe` only):
- C1 = I2 − I2_prev, then C2 = C1 − C1_prev, W-bit wrapping.
- Store I2_prev ← I2 and C1_prev ← C1.

Output scaling:
- y = C2 >>> (2·log2(R) − OUT_WIDTH + 1), arithmetic shift.
- Saturate y to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- Register y into `sample_out` and pulse `sample_valid_out`.
- Full-scale +1 input gives +2^(OUT_WIDTH−1), which saturates to 127. Full-scale −1 input gives −128 with no saturation.

Reset (asynchronous, any time):
- All counters, integrators, comb delays, synchronizer flops, `mic_clk_out`, `pdm_tick_out`, `sample_out` and `sample_valid_out` go to 0.
- An in-progress frame is discarded.
- After release, the tick counter restarts at 0.
- The first two output samples are CIC settling transients. They are still emitted with valid and are not suppressed.

## Timing
- `mic_clk_out` rises on the clock edge after `cnt` wraps to 0.
- The tick occurs one cycle after each `mic_clk_out` rise, every PERIOD cycles.
- First tick after reset release: cycle 2.
- Capture latency: the `mic_data_in` value two clocks before the tick edge is the bit captured.
- Integrators update on the tick edge.
- `sample_valid_out` is high in the cycle two clocks after the R-th tick of a frame, i.e. one clock after `dec_strobe`.
- Output period: exactly R·PERIOD clocks (8192 at defaults). Valid never asserts on two consecutive cycles.
- `sample_out` holds its value between strobes.
- `dec_strobe` and the next tick never coincide, because PERIOD ≥ 4.

## Structure
- Shared package `audio_pkg` holds:
  - `PDM_COUNT_PERIOD` and `NUM_PDM_SAMPLES` defaults.
  - `audio_sample_t` (signed 8-bit).
  - A `cic_width(order, r)` function.
- Sub-module `pdm_clock_gen` contains the counter, `mic_clk_out` and the tick edge detect. The same block is reused by the `pdm` transmitter instance.
- CIC integrator, comb and saturation logic stays inline.

## Test plan
1. Reset, then hold `mic_data_in`=1 → the third and later `sample_valid_out` give `sample_out`=127; strobes are spaced exactly 8192 clocks apart.
2. Hold `mic_data_in`=0 → steady `sample_out`=−128 (0x80).
3. Alternate 1,0 per tick → steady `sample_out`=0. Repeat with a 3:1 ones density → steady +64.
4. Run 10,000 frames of random bits with integrators deliberately wrapping → every sample matches a wide-precision CIC reference model bit-exactly.
5. Assert `rst_in` asynchronously mid-frame (between clock edges) → all outputs read 0 immediately. After release, the first tick is at cycle 2 and the first valid is at cycle 2 + (R−1)·PERIOD + 2.
6. Probe `mic_clk_out` → period 32 clocks, high for 16 clocks; exactly one `pdm_tick_out` per period, one cycle after the rising edge.
